// File: rtl/qmtech_board_pkg.sv
// Shared constants for the QMTECH daughter-board register bus: register
// addresses, event byte layout and status byte layout.
package qmtech_board_pkg;

    localparam logic [3:0] REG_BTN_STATE  = 4'd0;
    localparam logic [3:0] REG_BTN_EVENT  = 4'd1;
    localparam logic [3:0] REG_BTN_STATUS = 4'd2;
    localparam logic [3:0] REG_BTN_CTRL   = 4'd3;
    localparam logic [3:0] REG_BTN_FLUSH  = 4'd4;

    localparam int EV_VALID   = 7;
    localparam int EV_PRESS   = 6;
    localparam int EV_REPEAT  = 5;
    localparam int EV_IDX_MSB = 2;
    localparam int EV_IDX_LSB = 0;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 3;
    localparam int ST_CNT_MSB = 6;

    function automatic logic [7:0] make_event(input logic press, input logic rpt,
                                              input logic [2:0] idx);
        logic [7:0] ev;
        ev = '0;
        ev[EV_VALID] = 1'b1;
        ev[EV_PRESS] = press;
        ev[EV_REPEAT] = rpt;
        ev[EV_IDX_MSB:EV_IDX_LSB] = idx;
        return ev;
    endfunction

    function automatic logic [7:0] make_status(input logic [3:0] count, input logic ovf,
                                               input logic full, input logic empty);
        logic [7:0] st;
        st = '0;
        st[ST_CNT_MSB:ST_CNT_LSB] = count;
        st[ST_OVF] = ovf;
        st[ST_FULL] = full;
        st[ST_EMPTY] = empty;
        return st;
    endfunction

endpackage

// File: rtl/btn_event_fifo.sv
// Synchronous event FIFO with push/pop/flush. Flush wins over a same-cycle
// push; a push into a full FIFO is accepted only when a pop frees a slot.
module btn_event_fifo #(
    parameter int AW = 3,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  push_data,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem_q [2**AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == (AW+1)'(2**AW));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty && !flush;
        do_push  = push && (!full || do_pop) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: empty/count gate every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/qmtech_button_input.sv
// Button synchroniser/debouncer, edge-event FIFO and register bus for the
// QMTECH board. Define QMTECH_BTN_AUTOREPEAT_EN to add held-button auto-repeat.
module qmtech_button_input
    import qmtech_board_pkg::*;
#(
    parameter int          NUM_BUTTONS  = 5,
    parameter logic [15:0] TICK_CYCLES  = 16'd49999,
    parameter int          DEBOUNCE_LEN = 4,
    parameter int          FIFO_AW      = 3
`ifdef QMTECH_BTN_AUTOREPEAT_EN
    ,
    parameter int          REPEAT_DELAY = 500,
    parameter int          REPEAT_RATE  = 100
`endif
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic [3:0]             addr,
    input  logic [7:0]             wr_data,
    input  logic                   wr_en,
    input  logic                   rd_en,
    output logic [7:0]             rd_data,
    output logic                   irq
);

    logic [15:0]             tick_cnt_q, tick_cnt_d;
    logic [NUM_BUTTONS-1:0]  sync1_q, sync2_q;
    logic [DEBOUNCE_LEN-1:0] hist_q [NUM_BUTTONS];
    logic [DEBOUNCE_LEN-1:0] hist_d [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0]  state_q, state_d, pending_q, pending_d;
    logic [NUM_BUTTONS-1:0]  changed, ev_sel, rep_fire;
    logic                    ovf_q, ovf_d, irq_en_q, irq_en_d;
    logic [7:0]              rd_data_q, rd_data_d, ev_data;
    logic                    tick, ev_found, rep_bit, pop, flush;
    logic [2:0]              ev_idx;
    logic [7:0]              fifo_head;
    logic                    fifo_full, fifo_empty;
    logic [FIFO_AW:0]        fifo_count;
    logic                    unused_wr_bits;

`ifdef QMTECH_BTN_AUTOREPEAT_EN
    logic [15:0]            rep_cnt_q, rep_cnt_d;
    logic                   rep_run_q, rep_run_d;
    logic [NUM_BUTTONS-1:0] rep_flag_q, rep_flag_d, rep_sel;
`endif

    assign tick           = (tick_cnt_q == TICK_CYCLES);
    assign pop            = rd_en && (addr == REG_BTN_EVENT);
    assign flush          = wr_en && (addr == REG_BTN_FLUSH);
    assign rd_data        = rd_data_q;
    assign irq            = irq_en_q && !fifo_empty;
    assign unused_wr_bits = ^{wr_data[7:3], wr_data[1]};

    always_comb begin
        tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
        state_d    = state_q;
        // History holds raw pin samples, so all-zero means a stable press.
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            hist_d[i] = hist_q[i];
            if (tick) begin
                hist_d[i] = {hist_q[i][DEBOUNCE_LEN-2:0], sync2_q[i]};
                if (hist_d[i] == '0)   state_d[i] = 1'b1;
                else if (&hist_d[i])   state_d[i] = 1'b0;
            end
        end
        changed = state_d ^ state_q;

        ev_found = 1'b0;
        ev_idx   = 3'd0;
        ev_sel   = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                ev_found  = 1'b1;
                ev_idx    = 3'(i);
                ev_sel    = '0;
                ev_sel[i] = 1'b1;
            end
        end

`ifdef QMTECH_BTN_AUTOREPEAT_EN
        rep_sel = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (state_q[i]) begin
                rep_sel    = '0;
                rep_sel[i] = 1'b1;
            end
        end
        rep_cnt_d = rep_cnt_q;
        rep_run_d = rep_run_q;
        rep_fire  = '0;
        if (tick) begin
            if (changed != '0 || state_q == '0) begin
                rep_cnt_d = 16'd0;
                rep_run_d = 1'b0;
            end else if (rep_cnt_q == (rep_run_q ? 16'(REPEAT_RATE - 1)
                                                 : 16'(REPEAT_DELAY - 1))) begin
                rep_cnt_d = 16'd0;
                rep_run_d = 1'b1;
                rep_fire  = rep_sel;
            end else begin
                rep_cnt_d = rep_cnt_q + 16'd1;
            end
        end
        rep_flag_d = (rep_flag_q & ~ev_sel & ~changed) | rep_fire;
        rep_bit    = |(rep_flag_q & ev_sel);
`else
        rep_fire = '0;
        rep_bit  = 1'b0;
`endif

        ev_data   = make_event(|(state_q & ev_sel), rep_bit, ev_idx);
        pending_d = (pending_q & ~ev_sel) | changed | rep_fire;

        ovf_d = ovf_q;
        if (wr_en && addr == REG_BTN_STATUS && wr_data[ST_OVF]) ovf_d = 1'b0;
        if (ev_found && fifo_full && !pop && !flush)            ovf_d = 1'b1;

        irq_en_d = irq_en_q;
        if (wr_en && addr == REG_BTN_CTRL) irq_en_d = wr_data[0];

        rd_data_d = '0;
        case (addr)
            REG_BTN_STATE:  rd_data_d[NUM_BUTTONS-1:0] = state_q;
            REG_BTN_EVENT:  rd_data_d = fifo_empty ? 8'h00 : fifo_head;
            REG_BTN_STATUS: rd_data_d = make_status(4'(fifo_count), ovf_q, fifo_full, fifo_empty);
            REG_BTN_CTRL:   rd_data_d = {7'b0, irq_en_q};
            default:        rd_data_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            sync1_q    <= '1;
            sync2_q    <= '1;
            for (int i = 0; i < NUM_BUTTONS; i++) hist_q[i] <= '1;
            state_q    <= '0;
            pending_q  <= '0;
            ovf_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            sync1_q    <= buttons;
            sync2_q    <= sync1_q;
            hist_q     <= hist_d;
            state_q    <= state_d;
            pending_q  <= pending_d;
            ovf_q      <= ovf_d;
            irq_en_q   <= irq_en_d;
            rd_data_q  <= rd_data_d;
        end
    end

`ifdef QMTECH_BTN_AUTOREPEAT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rep_cnt_q  <= '0;
            rep_run_q  <= 1'b0;
            rep_flag_q <= '0;
        end else begin
            rep_cnt_q  <= rep_cnt_d;
            rep_run_q  <= rep_run_d;
            rep_flag_q <= rep_flag_d;
        end
    end
`endif

    btn_event_fifo #(.AW(FIFO_AW), .W(8)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (ev_found),
        .pop       (pop),
        .flush     (flush),
        .push_data (ev_data),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
